// File: rtl/multicycle_controller.sv
// Multi-cycle control unit for the 8-bit, 4-register processor.
// Owns PC, IR and the internal A/B/ALU-out/MDR latches, fetches over a
// ready-handshaked instruction port, sequences loads/stores over a
// ready-handshaked data port and drives the 4x8 register file ports.
module multicycle_controller #(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ready,
    input  logic [7:0] imem_data,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic [7:0] dmem_addr,
    output logic [7:0] dmem_wdata,
    input  logic       dmem_ready,
    input  logic [7:0] dmem_rdata,
    output logic [1:0] rf_read_reg1,
    output logic [1:0] rf_read_reg2,
    input  logic [7:0] rf_read_data1,
    input  logic [7:0] rf_read_data2,
    output logic       rf_write,
    output logic [1:0] rf_write_reg,
    output logic [7:0] rf_write_data,
    output logic [7:0] pc,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    logic [2:0] state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] alu_q, alu_d;
    logic [7:0] mdr_q, mdr_d;

    logic [1:0] op;
    logic [7:0] imm_sext;
    logic [7:0] jmp_sext;
    logic [2:0] after_instr;

    assign op       = ir_q[7:6];
    assign imm_sext = {{6{ir_q[1]}}, ir_q[1:0]};
    assign jmp_sext = {{2{ir_q[5]}}, ir_q[5:0]};

    // run is only looked at when an instruction retires (and in IDLE)
    assign after_instr = run ? S_FETCH : S_IDLE;

    // State register; asynchronous reset abandons any in-flight access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers (PC, IR, operand latches, ALU-out, MDR)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= PC_RESET;
            ir_q  <= 8'h00;
            a_q   <= 8'h00;
            b_q   <= 8'h00;
            alu_q <= 8'h00;
            mdr_q <= 8'h00;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            a_q   <= a_d;
            b_q   <= b_d;
            alu_q <= alu_d;
            mdr_q <= mdr_d;
        end
    end

    // Next-state logic; readies outside their own state are ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op)
                    OP_ADD:  state_d = S_WB;
                    OP_LW:   state_d = S_MEM;
                    OP_SW:   state_d = S_MEM;
                    default: state_d = after_instr;   // jump retires here
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    state_d = (op == OP_LW) ? S_WB : after_instr;
                end
            end
            S_WB: begin
                state_d = after_instr;
            end
            default: begin
                state_d = S_IDLE;                      // unused codes recover
            end
        endcase
    end

    // Datapath next-value logic, all arithmetic wraps mod 256
    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        a_d   = a_q;
        b_d   = b_q;
        alu_d = alu_q;
        mdr_d = mdr_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d = imem_data;
                    pc_d = pc_q + 8'd1;
                end
            end
            S_DECODE: begin
                a_d = rf_read_data1;
                b_d = rf_read_data2;
            end
            S_EXEC: begin
                case (op)
                    OP_ADD:  alu_d = a_q + b_q;
                    OP_J:    pc_d  = pc_q + jmp_sext;  // PC already points past J
                    default: alu_d = a_q + imm_sext;   // LW/SW effective address
                endcase
            end
            S_MEM: begin
                if (dmem_ready && (op == OP_LW)) begin
                    mdr_d = dmem_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    // Moore strobes decoded purely from state so reset kills them at once
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_write = 1'b0;
        case (state_q)
            S_FETCH: imem_req = 1'b1;
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op == OP_SW);
            end
            S_WB:    rf_write = 1'b1;
            default: begin
            end
        endcase
    end

    // Address/data buses come straight from registers, so they are held
    // stable for the whole wait and read as zero out of reset
    assign imem_addr     = pc_q;
    assign dmem_addr     = alu_q;
    assign dmem_wdata    = b_q;
    assign rf_read_reg1  = ir_q[5:4];
    assign rf_read_reg2  = ir_q[3:2];
    assign rf_write_reg  = (op == OP_LW) ? ir_q[3:2] : ir_q[1:0];
    assign rf_write_data = (op == OP_LW) ? mdr_q : alu_q;
    assign pc            = pc_q;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: models the register file and
// both memories, steps programs cycle by cycle and checks hand-computed values.
module tb_multicycle_controller;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;

    logic       clk;
    logic       reset;
    logic       run;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ready;
    logic [7:0] imem_data;
    logic       dmem_req;
    logic       dmem_we;
    logic [7:0] dmem_addr;
    logic [7:0] dmem_wdata;
    logic       dmem_ready;
    logic [7:0] dmem_rdata;
    logic [1:0] rf_read_reg1;
    logic [1:0] rf_read_reg2;
    logic [7:0] rf_read_data1;
    logic [7:0] rf_read_data2;
    logic       rf_write;
    logic [1:0] rf_write_reg;
    logic [7:0] rf_write_data;
    logic [7:0] pc;
    logic [2:0] state;

    // bench-side models and knobs
    logic [7:0] rf   [4];
    logic [7:0] imem [256];
    logic [7:0] dmem [256];
    logic       imem_ready_r;
    logic       imem_spur;
    logic       imem_hold;
    logic       dmem_hold;
    int         imem_wait;
    int         dmem_wait;
    int         icnt;
    int         dcnt;
    int         wr_count;
    int         st_count;
    int         overlap_cnt;
    logic [7:0] last_st_addr;
    logic [7:0] last_st_data;

    int n_tests;
    int n_fail;

    multicycle_controller #(.PC_RESET(8'h00)) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_data     (imem_data),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ready    (dmem_ready),
        .dmem_rdata    (dmem_rdata),
        .rf_read_reg1  (rf_read_reg1),
        .rf_read_reg2  (rf_read_reg2),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2),
        .rf_write      (rf_write),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .pc            (pc),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_read_data1 = rf[rf_read_reg1];
    assign rf_read_data2 = rf[rf_read_reg2];
    assign imem_ready    = imem_ready_r | imem_spur;

    // Memory responders: ready after a programmable number of wait cycles
    always @(negedge clk) begin
        if (imem_req && !imem_hold) begin
            if (icnt >= imem_wait) begin
                imem_ready_r = 1'b1;
                imem_data    = imem[imem_addr];
            end else begin
                imem_ready_r = 1'b0;
                icnt         = icnt + 1;
            end
        end else begin
            imem_ready_r = 1'b0;
            icnt         = 0;
        end
        if (dmem_req && !dmem_hold) begin
            if (dcnt >= dmem_wait) begin
                dmem_ready = 1'b1;
                dmem_rdata = dmem[dmem_addr];
            end else begin
                dmem_ready = 1'b0;
                dcnt       = dcnt + 1;
            end
        end else begin
            dmem_ready = 1'b0;
            dcnt       = 0;
        end
    end

    // Register-file write port, store log and port-overlap monitor
    always @(posedge clk) begin
        if (rf_write) begin
            rf[rf_write_reg] <= rf_write_data;
            wr_count = wr_count + 1;
            $display("[TB] rf write r%0d <= %02h", rf_write_reg, rf_write_data);
        end
        if (dmem_req && dmem_ready) begin
            if (dmem_we) begin
                dmem[dmem_addr] = dmem_wdata;
                st_count     = st_count + 1;
                last_st_addr = dmem_addr;
                last_st_data = dmem_wdata;
                $display("[TB] store mem[%02h] <= %02h", dmem_addr, dmem_wdata);
            end else begin
                $display("[TB] load  mem[%02h] -> %02h", dmem_addr, dmem_rdata);
            end
        end
        if (imem_req && imem_ready) begin
            $display("[TB] fetch pc=%02h instr=%02h", imem_addr, imem_data);
        end
        if (imem_req && dmem_req) begin
            overlap_cnt = overlap_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int wr0;
        n_tests = 0;       n_fail = 0;
        wr_count = 0;      st_count = 0;      overlap_cnt = 0;
        last_st_addr = 8'h00;  last_st_data = 8'h00;
        reset = 1'b1;      run = 1'b0;
        imem_ready_r = 1'b0;   imem_data = 8'h00;  imem_spur = 1'b0;
        dmem_ready = 1'b0;     dmem_rdata = 8'h00;
        imem_hold = 1'b0;  dmem_hold = 1'b0;
        imem_wait = 0;     dmem_wait = 3;
        icnt = 0;          dcnt = 0;
        for (int i = 0; i < 256; i++) begin
            imem[i] = 8'h00;
            dmem[i] = 8'h00;
        end
        rf[0] = 8'h00; rf[1] = 8'hF0; rf[2] = 8'h20; rf[3] = 8'h00;
        // program: ADD r3=r1+r2; LW r2,-1(r0); SW r3,1(r1); ADD; SW; J -2
        imem[0] = 8'h1B; imem[1] = 8'h4B; imem[2] = 8'h9D;
        imem[3] = 8'h00; imem[4] = 8'h9D; imem[5] = 8'hFE;
        dmem[8'hFF] = 8'hA5;

        // ---- reset state ----
        tick(); tick();
        check("rst_state",     32'(state), 32'(S_IDLE));
        check("rst_imem_req",  32'(imem_req), 0);
        check("rst_dmem_req",  32'(dmem_req), 0);
        check("rst_rf_write",  32'(rf_write), 0);
        check("rst_pc",        32'(pc), 32'h00);
        check("rst_wdata",     32'(rf_write_data), 0);
        check("rst_dmem_addr", 32'(dmem_addr), 0);
        run = 1'b1; reset = 1'b0;

        // ---- ADD with wrap: 0xF0 + 0x20 = 0x10 into r3 ----
        tick();
        check("add_fetch_state", 32'(state), 32'(S_FETCH));
        check("add_fetch_req",   32'(imem_req), 1);
        check("add_fetch_addr",  32'(imem_addr), 32'h00);
        tick();
        check("add_decode_pc",   32'(pc), 32'h01);
        tick();
        check("add_exec_nowr",   32'(rf_write), 0);
        tick();
        check("add_wb_write",    32'(rf_write), 1);
        check("add_wb_reg",      32'(rf_write_reg), 3);
        check("add_wb_data",     32'(rf_write_data), 32'h10);

        // ---- LW with 3 wait cycles: addr 0x00 + (-1) = 0xFF ----
        wait_state(S_MEM, 10, "lw_reach_mem");
        for (int i = 0; i < 4; i++) begin
            check("lw_mem_req",  32'(dmem_req), 1);
            check("lw_mem_we",   32'(dmem_we), 0);
            check("lw_mem_addr", 32'(dmem_addr), 32'hFF);
            tick();
        end
        check("lw_wb_state", 32'(state), 32'(S_WB));
        check("lw_wb_write", 32'(rf_write), 1);
        check("lw_wb_reg",   32'(rf_write_reg), 2);
        check("lw_wb_data",  32'(rf_write_data), 32'hA5);
        dmem_wait = 0;
        rf[1] = 8'h10; rf[3] = 8'h33;

        // ---- SW: mem[0x10+1] = r3 ----
        wait_state(S_MEM, 10, "sw_reach_mem");
        wr0 = wr_count;
        check("sw_mem_req",   32'(dmem_req), 1);
        check("sw_mem_we",    32'(dmem_we), 1);
        check("sw_mem_addr",  32'(dmem_addr), 32'h11);
        check("sw_mem_wdata", 32'(dmem_wdata), 32'h33);
        wait_state(S_FETCH, 5, "sw_to_fetch");
        check("sw_next_pc",   32'(pc), 32'h03);
        check("sw_no_rfwrite", 32'(wr_count), 32'(wr0));
        check("sw_store_cnt", 32'(st_count), 1);
        check("sw_store_data", 32'(last_st_data), 32'h33);

        // ---- J -2 at pc 5 lands on 4, three cycles ----
        n = 0;
        while (!(state == S_FETCH && pc == 8'h05) && n < 30) begin
            tick();
            n = n + 1;
        end
        check("jmp_reach_fetch", 32'(pc), 32'h05);
        tick(); tick(); tick();
        check("jmp_state",  32'(state), 32'(S_FETCH));
        check("jmp_target", 32'(imem_addr), 32'h04);

        // ---- run dropped during SW wait: store finishes, then IDLE ----
        dmem_wait = 2;
        wait_state(S_MEM, 10, "rundrop_reach_mem");
        run = 1'b0;
        n = 0;
        while (state == S_MEM && n < 10) begin
            tick();
            n = n + 1;
        end
        check("rundrop_state",  32'(state), 32'(S_IDLE));
        check("rundrop_stores", 32'(st_count), 3);
        check("rundrop_pc",     32'(pc), 32'h05);
        imem_spur = 1'b1;          // stray fetch-ready while IDLE
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_no_ireq", 32'(imem_req), 0);
        end
        imem_spur = 1'b0;
        check("idle_spur_state", 32'(state), 32'(S_IDLE));
        check("idle_spur_pc",    32'(pc), 32'h05);

        // ---- reset asserted mid-FETCH ----
        imem_hold = 1'b1;
        run = 1'b1;
        tick(); tick();
        check("midfetch_req", 32'(imem_req), 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_ireq",   32'(imem_req), 0);
        check("midrst_state",  32'(state), 32'(S_IDLE));
        check("midrst_pc",     32'(pc), 32'h00);
        check("midrst_daddr",  32'(dmem_addr), 0);
        check("midrst_dwdata", 32'(dmem_wdata), 0);
        check("midrst_rreg1",  32'(rf_read_reg1), 0);
        imem_hold = 1'b0;
        imem[0] = 8'hFE;
        imem[8'hFF] = 8'h00;
        tick();
        reset = 1'b0;
        tick();
        check("rel_state", 32'(state), 32'(S_FETCH));
        check("rel_addr",  32'(imem_addr), 32'h00);

        // ---- J -2 from 0 goes to 0xFF, fetch at 0xFF wraps PC ----
        tick(); tick(); tick();
        check("wrapj_addr", 32'(imem_addr), 32'hFF);
        imem[0] = 8'h9D;
        dmem_hold = 1'b1;
        tick();
        check("wrap_state", 32'(state), 32'(S_DECODE));
        check("wrap_pc",    32'(pc), 32'h00);

        // ---- reset asserted during a stalled store ----
        wait_state(S_MEM, 20, "rstmem_reach_mem");
        check("rstmem_req_before", 32'(dmem_req), 1);
        #2 reset = 1'b1;
        #1;
        check("rstmem_dreq",  32'(dmem_req), 0);
        check("rstmem_dwe",   32'(dmem_we), 0);
        check("rstmem_state", 32'(state), 32'(S_IDLE));
        run = 1'b0;
        dmem_hold = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("no_port_overlap", 32'(overlap_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
